// File: rtl/seq_div8x4.sv
//==============================================================================
// Module   : seq_div8x4
// Brief    : 8-bit / 4-bit unsigned sequential restoring divider, one quotient
//            bit per clock, MSB first. Results are registered and held until
//            the next accepted start.
// Options  : DIV_ZERO_CHECK_EN - when defined, a zero divisor skips the
//            iterations, finishes one cycle after accept and raises divz.
//            When undefined, divz is tied low and a zero divisor takes the
//            normal 8-cycle path (quotient all ones, remainder = n[3:0]).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_div8x4 (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n,
  input  logic [3:0] d,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       ready,
  output logic       busy,
  output logic       divz
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after the last step this register holds the complete quotient.
  logic [7:0] r_work;
  logic [3:0] r_den;
  // Only four remainder bits are stored: between steps the remainder is below
  // the divisor. The fifth bit exists only in the shifted value w_shift.
  logic [3:0] r_rem;
  logic [2:0] r_cnt;
  logic [7:0] r_q;
  logic [3:0] r_r;
  logic       r_ready;
  logic       r_busy;

  logic [4:0] w_shift;
  logic       w_ge;
  logic [3:0] w_sub;
  logic [3:0] w_rem_next;
  logic [7:0] w_work_next;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // When the subtraction happens the true difference is below 16, so the low
  // four bits of the 4-bit subtraction are exact.
  always_comb begin
    w_shift     = {r_rem, r_work[7]};
    w_ge        = (w_shift >= {1'b0, r_den});
    w_sub       = w_shift[3:0] - r_den;
    w_rem_next  = w_ge ? w_sub : w_shift[3:0];
    w_work_next = {r_work[6:0], w_ge};
  end

`ifdef DIV_ZERO_CHECK_EN
  logic r_zero;
  logic r_divz;
  assign divz = r_divz;
`else
  assign divz = 1'b0;
`endif

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= 8'd0;
      r_den   <= 4'd0;
      r_rem   <= 4'd0;
      r_cnt   <= 3'd0;
      r_q     <= 8'd0;
      r_r     <= 4'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      r_zero  <= 1'b0;
      r_divz  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_work  <= n;
            r_den   <= d;
            r_rem   <= 4'd0;
            r_cnt   <= 3'd7;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            r_zero  <= (d == 4'd0);
            if (d != 4'd0) begin
              r_divz <= 1'b0;
            end
`endif
          end
        end
        ST_RUN: begin
`ifdef DIV_ZERO_CHECK_EN
          if (r_zero) begin
            // Zero divisor: publish the fixed result without iterating.
            r_q     <= 8'hFF;
            r_r     <= r_work[3:0];
            r_divz  <= 1'b1;
            r_zero  <= 1'b0;
            r_cnt   <= 3'd0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else
`endif
          begin
            r_rem  <= w_rem_next;
            r_work <= w_work_next;
            r_cnt  <= r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              r_q     <= w_work_next;
              r_r     <= w_rem_next;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign q     = r_q;
  assign r     = r_r;
  assign ready = r_ready;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seq_div8x4.sv
//==============================================================================
// Module   : tb_seq_div8x4
// Brief    : Scoreboard bench for seq_div8x4. Stimulus pushes the expected
//            result, accept cycle and latency; a monitor pops on each rising
//            edge of ready and compares. Honours DIV_ZERO_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_div8x4;

  logic       ck;
  logic       rst;
  logic       start;
  logic [7:0] n;
  logic [3:0] d;
  logic [7:0] q;
  logic [3:0] r;
  logic       ready;
  logic       busy;
  logic       divz;

`ifdef DIV_ZERO_CHECK_EN
  localparam int   ZLAT  = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int   ZLAT  = 8;
  localparam logic ZFLAG = 1'b0;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         acc;
    int         lat;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic ready_q = 1'b0;

  seq_div8x4 dut (
    .ck    (ck),
    .rst   (rst),
    .start (start),
    .n     (n),
    .d     (d),
    .q     (q),
    .r     (r),
    .ready (ready),
    .busy  (busy),
    .divz  (divz)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  always @(negedge ck) begin
    if (rst) begin
      ready_q = 1'b0;
    end else begin
      checks++;
      if (busy && ready) begin
        errors++;
        $display("FAIL busy_ready_overlap at cycle %0d", cyc);
      end
      if (ready && !ready_q) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: q=%0h r=%0h", q, r);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (q !== e.q || r !== e.r || divz !== e.z || (cyc - e.acc) != e.lat) begin
            errors++;
            $display("FAIL result_%s: got q=%0h r=%0h divz=%b lat=%0d, expected q=%0h r=%0h divz=%b lat=%0d",
                     e.nm, q, r, divz, cyc - e.acc, e.q, e.r, e.z, e.lat);
          end
        end
      end
      ready_q = ready;
    end
  end

  // Called at a negedge: queue the expectation and pulse start for one edge.
  task automatic launch(input logic [7:0] nn, input logic [3:0] dd,
                        input logic [7:0] eq, input logic [3:0] er, input string nm);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.z   = (dd == 4'd0) ? ZFLAG : 1'b0;
    e.lat = (dd == 4'd0) ? ZLAT : 8;
    e.acc = cyc + 1;
    e.nm  = nm;
    sb.push_back(e);
    n     = nn;
    d     = dd;
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int nb);
    int i;
    i  = 0;
    nb = 0;
    while (!ready && i < 40) begin
      if (busy) nb++;
      @(negedge ck);
      i++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, expected 1", ready, i);
    end
  endtask

  task automatic run_one(input logic [7:0] nn, input logic [3:0] dd,
                         input logic [7:0] eq, input logic [3:0] er, input string nm);
    int nb;
    launch(nn, dd, eq, er, nm);
    wait_ready(nb);
    chk({"busy_cycles_", nm}, nb, (dd == 4'd0) ? ZLAT : 8);
  endtask

  initial begin
    int nb;
    int rc;
    rst   = 1'b1;
    start = 1'b0;
    n     = 8'd0;
    d     = 4'd0;
    repeat (3) @(negedge ck);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_flags", {ready, busy, divz}, 0);
    rst = 1'b0;
    @(negedge ck);

    // 100 / 7 = 14 rem 2, busy for the whole run.
    run_one(8'h64, 4'h7, 8'h0E, 4'h2, "64_7");
    repeat (4) @(negedge ck);
    chk("done_persist_ready", ready, 1);
    chk("done_persist_q", q, 8'h0E);

    run_one(8'hFF, 4'hF, 8'h11, 4'h0, "FF_F");
    // Previous result must stay visible during the next run.
    launch(8'h05, 4'h9, 8'h00, 4'h5, "05_9");
    repeat (3) @(negedge ck);
    chk("hold_q_in_run", q, 8'h11);
    chk("hold_r_in_run", r, 4'h0);
    chk("run_flags", {ready, busy}, 2'b01);
    wait_ready(nb);

    // A start pulse with new operands mid-run must be ignored.
    launch(8'h64, 4'h7, 8'h0E, 4'h2, "ignore");
    repeat (2) @(negedge ck);
    n     = 8'hFF;
    d     = 4'hF;
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    wait_ready(nb);

    // Zero divisor.
    run_one(8'hA7, 4'h0, 8'hFF, 4'h7, "A7_0");
    repeat (2) @(negedge ck);
    chk("divz_held", divz, ZFLAG);
    chk("divz_q_held", q, 8'hFF);
    // A nonzero divisor clears divz.
    run_one(8'h64, 4'h7, 8'h0E, 4'h2, "divz_clear");

    // Start held high: a result every 9 edges, ready high one cycle each.
    sb.push_back('{8'h0E, 4'h2, 1'b0, cyc + 1,  8, "b2b0"});
    sb.push_back('{8'h0E, 4'h2, 1'b0, cyc + 10, 8, "b2b1"});
    sb.push_back('{8'h0E, 4'h2, 1'b0, cyc + 19, 8, "b2b2"});
    n     = 8'h64;
    d     = 4'h7;
    start = 1'b1;
    rc    = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge ck);
      if (ready) rc++;
    end
    start = 1'b0;
    chk("b2b_ready_cycles", rc, 3);

    // Reset between edges mid-run.
    run_one(8'hFF, 4'hF, 8'h11, 4'h0, "pre_abort");
    launch(8'h64, 4'h7, 8'h0E, 4'h2, "abort");
    repeat (4) @(posedge ck);
    #2 rst = 1'b1;
    #1;
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_flags", {ready, busy, divz}, 0);
    sb.delete();
    @(negedge ck);
    rst = 1'b0;
    run_one(8'h64, 4'h7, 8'h0E, 4'h2, "after_rst");

    // Full sweep against the arithmetic reference.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        logic [7:0] eq;
        logic [3:0] er;
        eq = 8'(a / b);
        er = 4'(a % b);
        run_one(8'(a), 4'(b), eq, er, "sweep");
      end
    end

    repeat (2) @(negedge ck);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
